// File: rtl/shift_div_pkg.sv
// shift_div_pkg: operating modes shared by the shift/divide pipeline and its users.
package shift_div_pkg;
  typedef enum logic [1:0] {
    MODE_LSR       = 2'd0,
    MODE_ASR       = 2'd1,
    MODE_DIV_TRUNC = 2'd2,
    MODE_DIV_RND   = 2'd3
  } mode_t;
endpackage

// File: rtl/shift_div_stage.sv
// shift_div_stage: one registered conditional right shift by DIST, selected by the matching shamt bit.
module shift_div_stage #(
  parameter int W    = 9,
  parameter int SW   = 3,
  parameter int DIST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          in_valid,
  input  logic [W-1:0]  in_x,
  input  logic [SW-1:0] in_s,
  input  logic          in_inexact,
  output logic          out_valid,
  output logic [W-1:0]  out_x,
  output logic [SW-1:0] out_s,
  output logic          out_inexact
);
  localparam int B = $clog2(DIST);
  always_ff @(posedge clk)
    if (rst) begin
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_s       <= '0;
      out_inexact <= 1'b0;
    end else if (advance) begin
      out_valid   <= in_valid;
      out_x       <= in_s[B] ? {{DIST{in_x[W-1]}}, in_x[W-1:DIST]} : in_x;
      out_s       <= in_s;
      out_inexact <= in_inexact;
    end
endmodule

// File: rtl/pipelined_signed_divide_by_power_of_2.sv
// pipelined_signed_divide_by_power_of_2: elastic shift/divide by 2^s; stage 0 extends and biases,
// then one conditional shift stage per shamt bit.
module pipelined_signed_divide_by_power_of_2
  import shift_div_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [SW-1:0] in_shamt,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_res,
  output logic          out_inexact
);
  localparam int W = N + 1;
  localparam logic [W-1:0] ONE = W'(1);
  logic          advance;
  logic [W-1:0]  a_ext, mask, bias;
  logic          v  [SW+1];
  logic [W-1:0]  x  [SW+1];
  logic [SW-1:0] s  [SW+1];
  logic          ix [SW+1];
  logic          unused_bits;
  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("N must be a power of two >= 4");
  end
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  // one spare top bit keeps the biased value exact before shifting
  assign a_ext = {in_mode != MODE_LSR && in_a[N-1], in_a};
  assign mask  = (ONE << in_shamt) - ONE;
  assign bias  = in_mode == MODE_DIV_TRUNC && in_a[N-1] ? mask :
                 in_mode == MODE_DIV_RND && in_shamt != '0 ? ONE << (in_shamt - 1'b1) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      v[0]  <= 1'b0;
      x[0]  <= '0;
      s[0]  <= '0;
      ix[0] <= 1'b0;
    end else if (advance) begin
      v[0]  <= in_valid;
      x[0]  <= a_ext + bias;
      s[0]  <= in_shamt;
      ix[0] <= |(a_ext & mask);
    end
  for (genvar i = 0; i < SW; i++) begin : g_stage
    shift_div_stage #(.W(W), .SW(SW), .DIST(1 << i)) u_stage (
      .clk(clk), .rst(rst), .advance(advance),
      .in_valid(v[i]), .in_x(x[i]), .in_s(s[i]), .in_inexact(ix[i]),
      .out_valid(v[i+1]), .out_x(x[i+1]), .out_s(s[i+1]), .out_inexact(ix[i+1])
    );
  end
  assign out_valid   = v[SW];
  assign out_res     = x[SW][N-1:0];
  assign out_inexact = ix[SW];
  assign unused_bits = ^{x[SW][N], s[SW]};
endmodule
